// File: rtl/rom_word_fetcher.sv
// Burst fetcher between a synchronous byte ROM and 32-bit consumers: issues one
// byte read per cycle, packs bytes little-endian and queues words in a small FIFO.
module rom_word_fetcher #(
  parameter int ADDR_WIDTH = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic                  abort,
  output logic                  rom_cen,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            words_left;
  logic [1:0]            byte_idx;
  logic [1:0]            rom_lane;
  logic                  rom_last;
  logic                  cap_vld;
  logic [1:0]            cap_lane;
  logic                  cap_last;
  logic [1:0]            inflight_words;
  logic [23:0]           asm_word;

  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  start_word;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [1:0]            cur_idx;
  logic [8:0]            cur_left;
  logic [CW:0]           occupancy;

  // The accept edge doubles as the first issue edge, so IDLE supplies the
  // request fields directly instead of the latched ones.
  always_comb begin
    cur_addr   = addr;
    cur_idx    = byte_idx;
    cur_left   = words_left;
    if (state == IDLE) begin
      cur_addr = req_addr;
      cur_idx  = 2'd0;
      cur_left = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
    end
    accept     = req_valid & req_ready & ~abort;
    pop        = out_valid & out_ready;
    push       = cap_vld & (cap_lane == 2'd3);
    occupancy  = (CW+1)'(fifo_count) + (CW+1)'(inflight_words) - (CW+1)'(pop);
    issue      = ~abort & ((state == READ) | accept)
               & ((cur_idx != 2'd0) | (occupancy < (CW+1)'(FIFO_DEPTH)));
    start_word = issue & (cur_idx == 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr           <= '0;
      words_left     <= '0;
      byte_idx       <= '0;
      rom_cen        <= 1'b0;
      rom_addr       <= '0;
      rom_lane       <= '0;
      rom_last       <= 1'b0;
      cap_vld        <= 1'b0;
      cap_lane       <= '0;
      cap_last       <= 1'b0;
      inflight_words <= '0;
      asm_word       <= '0;
    end else if (abort) begin
      state          <= IDLE;
      byte_idx       <= '0;
      rom_cen        <= 1'b0;
      cap_vld        <= 1'b0;
      inflight_words <= '0;
    end else begin
      rom_cen        <= issue;
      cap_vld        <= rom_cen;
      cap_lane       <= rom_lane;
      cap_last       <= rom_last;
      inflight_words <= inflight_words + {1'b0, start_word} - {1'b0, push};
      if (issue) begin
        rom_addr <= cur_addr;
        rom_lane <= cur_idx;
        rom_last <= (cur_left == 9'd1);
        addr     <= cur_addr + ADDR_WIDTH'(1);
        byte_idx <= cur_idx + 2'd1;
        if (cur_idx == 2'd3) begin
          words_left <= cur_left - 9'd1;
          state      <= (cur_left == 9'd1) ? IDLE : READ;
        end else begin
          words_left <= cur_left;
          state      <= READ;
        end
      end else if (accept) begin
        addr       <= req_addr;
        byte_idx   <= '0;
        words_left <= cur_left;
        state      <= READ;
      end
      if (cap_vld) begin
        case (cap_lane)
          2'd0:    asm_word[7:0]   <= rom_data;
          2'd1:    asm_word[15:8]  <= rom_data;
          2'd2:    asm_word[23:16] <= rom_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= {rom_data, asm_word};
        fifo_last[wr_ptr] <= cap_last;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    out_valid = (fifo_count != '0);
    out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;
    busy      = (state != IDLE) | out_valid;
  end

endmodule

// File: tb/tb_rom_word_fetcher.sv
// Scoreboard bench for rom_word_fetcher: a behavioural byte ROM feeds the DUT,
// expected words are queued at request acceptance and compared on every pop.
module tb_rom_word_fetcher;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_len = '0;
  logic          abort = 1'b0;
  logic          rom_cen;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data = '0;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          busy;

  logic [7:0]    rom [1 << AW];
  logic [32:0]   sb [$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            n_pops = 0;
  int            n_lasts = 0;
  int            cen_cnt = 0;

  always #5 clk = ~clk;

  rom_word_fetcher #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .abort(abort), .rom_cen(rom_cen),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  always @(posedge clk)
    if (rom_cen) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rom_cen) cen_cnt++;
    if (out_valid && out_ready) begin
      n_pops++;
      if (out_last) n_lasts++;
      if (sb.size() == 0) begin
        check("extra_pop", 64'(out_data), 64'hdead);
      end else begin
        check("word", {31'd0, out_last, out_data}, {31'd0, sb[0]});
        void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [7:0] len);
    logic acc;
    int   tries;
    int   nw;
    logic [AW-1:0] p;
    req_addr  = a;
    req_len   = len;
    req_valid = 1'b1;
    tries     = 0;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 2000);
    req_valid = 1'b0;
    if (!acc) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      nw = (len == 8'd0) ? 256 : int'(len);
      p  = a;
      for (int w = 0; w < nw; w++) begin
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
          d[k*8 +: 8] = rom[p];
          p = p + AW'(1);
        end
        sb.push_back({(w == nw - 1), d});
      end
    end
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < limit) begin
      cyc(1);
      t++;
    end
    if (t >= limit) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c0;
    int p0;
    int l0;
    int t;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'(i * 7 + (i >> 8) * 13 + 1);
    rom[16'h10] = 8'h11;
    rom[16'h11] = 8'h22;
    rom[16'h12] = 8'h33;
    rom[16'h13] = 8'h44;

    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rom_cen",   64'(rom_cen),   64'd0);
    check("rst_rom_addr",  64'(rom_addr),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(2);

    // single word, exact latency
    out_ready = 1'b1;
    send(AW'(16'h0010), 8'd1);
    for (int i = 0; i < 4; i++) begin
      check("t1_cen",  64'(rom_cen),  64'd1);
      check("t1_addr", 64'(rom_addr), 64'(16'h10 + i));
      cyc(1);
    end
    check("t1_cen_c5",   64'(rom_cen),   64'd0);
    check("t1_valid_c5", 64'(out_valid), 64'd0);
    cyc(1);
    check("t1_valid_c6", 64'(out_valid), 64'd1);
    check("t1_data_c6",  64'(out_data),  64'h44332211);
    check("t1_last_c6",  64'(out_last),  64'd1);
    cyc(1);
    check("t1_busy_after_pop", 64'(busy), 64'd0);

    // address wrap
    send(AW'(16'h7FFE), 8'd2);
    for (int i = 0; i < 8; i++) begin
      check("t2_cen",  64'(rom_cen),  64'd1);
      check("t2_addr", 64'(rom_addr), 64'((16'h7FFE + i) & 16'h7FFF));
      cyc(1);
    end
    drain(200);

    // 256-word burst with random back-pressure
    p0 = n_pops;
    l0 = n_lasts;
    send(AW'(16'h1234), 8'd0);
    t = 0;
    while ((sb.size() != 0 || busy) && t < 6000) begin
      out_ready = 1'($urandom_range(0, 1));
      cyc(1);
      t++;
    end
    out_ready = 1'b1;
    check("t3_words", 64'(n_pops - p0), 64'd256);
    check("t3_lasts", 64'(n_lasts - l0), 64'd1);

    // FIFO full stall, then one pop releases exactly one word
    out_ready = 1'b0;
    c0 = cen_cnt;
    send(AW'(16'h0400), 8'd8);
    cyc(40);
    check("t4_cen_full",   64'(cen_cnt - c0), 64'd16);
    check("t4_cen_low",    64'(rom_cen),      64'd0);
    check("t4_valid",      64'(out_valid),    64'd1);
    check("t4_head",       64'(out_data),     64'(sb[0][31:0]));
    cyc(5);
    check("t4_head_stable", {31'd0, out_last, out_data}, {31'd0, sb[0]});
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(20);
    check("t4_cen_one_more", 64'(cen_cnt - c0), 64'd20);
    out_ready = 1'b1;
    drain(400);

    // abort mid-burst
    send(AW'(16'h0100), 8'd4);
    cyc(2);
    abort = 1'b1;
    sb.delete();
    cyc(1);
    abort = 1'b0;
    check("t5_cen",       64'(rom_cen),   64'd0);
    check("t5_valid",     64'(out_valid), 64'd0);
    check("t5_req_ready", 64'(req_ready), 64'd1);
    cyc(6);
    send(AW'(16'h0200), 8'd3);
    drain(400);

    // back-to-back requests
    send(AW'(16'h0300), 8'd2);
    send(AW'(16'h0333), 8'd3);
    send(AW'(16'h4001), 8'd1);
    drain(400);

    // reset mid-burst
    send(AW'(16'h0800), 8'd4);
    cyc(7);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("t7_valid", 64'(out_valid), 64'd0);
    check("t7_busy",  64'(busy),      64'd0);
    check("t7_cen",   64'(rom_cen),   64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(2);
    send(AW'(16'h0010), 8'd1);
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
